// File: rtl/key_debounce.sv
// Push-button conditioner: synchronises an active-low key, debounces it and
// produces press/release/long-press strobes plus a wrapping press counter.
module key_debounce #(
  parameter int CNT_DB   = 240_000,
  parameter int CNT_LONG = 12_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic       key_state,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_cnt
);

  localparam int DB_W   = $clog2(CNT_DB);
  localparam int LONG_W = $clog2(CNT_LONG);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(CNT_DB - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(CNT_LONG - 1);
  localparam logic [LONG_W-1:0] LONG_ARM  = LONG_W'(CNT_LONG - 2);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t              state_reg;
  logic [1:0]          sync_reg;
  logic [DB_W-1:0]     db_cnt_reg;
  logic [LONG_W-1:0]   long_cnt_reg;
  logic                key_sync;

  // Sync chain resets to "released" so a key held through reset needs a full debounce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], key_n};
    end
  end

  assign key_sync = ~sync_reg[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      db_cnt_reg    <= '0;
      long_cnt_reg  <= '0;
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_cnt     <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (key_sync) begin
            state_reg  <= PRESS_WAIT;
            db_cnt_reg <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_sync) begin
            state_reg  <= IDLE;
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg    <= PRESSED;
            press_pulse  <= 1'b1;
            key_state    <= 1'b1;
            press_cnt    <= press_cnt + 8'd1;
            long_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
        PRESSED: begin
          if (!key_sync) begin
            state_reg  <= RELEASE_WAIT;
            db_cnt_reg <= '0;
          end else if (long_cnt_reg != LONG_LAST) begin
            // Saturation at LONG_LAST keeps long_pulse to one per press, even across bounce.
            long_cnt_reg <= long_cnt_reg + 1'b1;
            if (long_cnt_reg == LONG_ARM) begin
              long_pulse <= 1'b1;
            end
          end
        end
        RELEASE_WAIT: begin
          if (key_sync) begin
            state_reg  <= PRESSED;
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg     <= IDLE;
            release_pulse <= 1'b1;
            key_state     <= 1'b0;
            long_cnt_reg  <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: expected pulse edges are queued as stimulus is
// driven and matched against the DUT strobes each cycle.
module tb_key_debounce;

  localparam int CNT_DB   = 4;
  localparam int CNT_LONG = 20;
  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  logic       clk;
  logic       rst;
  logic       key_n;
  logic       key_state;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_cnt;

  typedef struct {
    int kind;
    int edge_no;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        ev;
  int         edge_cnt = 0;
  int         checks = 0;
  int         errors = 0;
  int         press_seen = 0;
  int         release_seen = 0;
  int         long_seen = 0;
  logic [7:0] exp_cnt;
  logic [2:0] pulses;
  logic [2:0] consumed;

  key_debounce #(
    .CNT_DB  (CNT_DB),
    .CNT_LONG(CNT_LONG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_n        (key_n),
    .key_state    (key_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_cnt    (press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Scoreboard: every strobe seen must match a queued expectation for this exact edge.
  always @(posedge clk) begin
    #1;
    pulses   = {long_pulse, release_pulse, press_pulse};
    consumed = 3'b000;
    while (exp_q.size() > 0 && exp_q[0].edge_no == edge_cnt) begin
      ev = exp_q.pop_front();
      checks++;
      assert (pulses[ev.kind] === 1'b1) else begin
        errors++;
        $error("FAIL pulse_kind%0d edge %0d: observed %b, expected 1", ev.kind, edge_cnt, pulses[ev.kind]);
      end
      consumed[ev.kind] = 1'b1;
    end
    checks++;
    assert ((pulses & ~consumed) === 3'b000) else begin
      errors++;
      $error("FAIL unexpected_pulse edge %0d: observed %b, expected 000", edge_cnt, pulses & ~consumed);
    end
    if (press_pulse === 1'b1) press_seen++;
    if (release_pulse === 1'b1) release_seen++;
    if (long_pulse === 1'b1) long_seen++;
  end

  function automatic void push(input int kind, input int e);
    ev_t item;
    item.kind    = kind;
    item.edge_no = e;
    exp_q.push_back(item);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until_edge(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_key_state"}, {31'd0, key_state}, 32'd0);
    check({tag, "_pulses"}, {29'd0, long_pulse, release_pulse, press_pulse}, 32'd0);
    check({tag, "_press_cnt"}, {24'd0, press_cnt}, 32'd0);
  endtask

  initial begin
    int n;
    int m;
    int p0;
    int r0;
    logic bounce [5];

    rst     = 1'b1;
    key_n   = 1'b1;
    exp_cnt = 8'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Glitch: 3 low samples never reach the accept point.
    key_n = 1'b0;
    repeat (3) @(negedge clk);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch_key_state", {31'd0, key_state}, 32'd0);
    check("glitch_press_cnt", {24'd0, press_cnt}, {24'd0, exp_cnt});
    check("glitch_press_seen", press_seen, 0);

    // Held press: press on edge N+6; long_cnt counts 0..19 from there, so long fires 19 edges later.
    key_n = 1'b0;
    n = edge_cnt + 1;
    push(K_PRESS, n + 6);
    push(K_LONG, n + 6 + CNT_LONG - 1);
    exp_cnt = exp_cnt + 8'd1;
    wait_until_edge(n + 7);
    check("press_key_state", {31'd0, key_state}, 32'd1);
    check("press_press_cnt", {24'd0, press_cnt}, {24'd0, exp_cnt});
    wait_until_edge(n + 36);
    check("hold_long_seen", long_seen, 1);

    // Bouncy release: the last rising sample is at m+4, so release lands on m+10.
    bounce = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    m = edge_cnt + 1;
    push(K_RELEASE, m + 4 + 6);
    for (int k = 0; k < 5; k++) begin
      key_n = bounce[k];
      @(negedge clk);
    end
    wait_until_edge(m + 12);
    check("bounce_key_state", {31'd0, key_state}, 32'd0);
    check("bounce_press_cnt", {24'd0, press_cnt}, {24'd0, exp_cnt});
    check("bounce_press_seen", press_seen, 1);
    check("bounce_long_seen", long_seen, 1);
    check("bounce_release_seen", release_seen, 1);

    // Reset in PRESS_WAIT with key held; press re-debounced from the first edge after release.
    key_n = 1'b0;
    n = edge_cnt + 1;
    wait_until_edge(n + 4);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
    n = edge_cnt + 1;
    push(K_PRESS, n + 6);
    wait_until_edge(n);
    check_idle_outputs("post_mid_reset");
    exp_cnt = exp_cnt + 8'd1;
    wait_until_edge(n + 8);
    check("rst_press_key_state", {31'd0, key_state}, 32'd1);
    check("rst_press_cnt", {24'd0, press_cnt}, {24'd0, exp_cnt});
    key_n = 1'b1;
    m = edge_cnt + 1;
    push(K_RELEASE, m + 6);
    wait_until_edge(m + 8);
    check("rst_release_key_state", {31'd0, key_state}, 32'd0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
    @(negedge clk);
    check("clear_press_cnt", {24'd0, press_cnt}, 32'd0);

    // 256 clean presses: counter wraps back to 0.
    p0 = press_seen;
    r0 = release_seen;
    for (int i = 1; i <= 256; i++) begin
      key_n = 1'b0;
      n = edge_cnt + 1;
      push(K_PRESS, n + 6);
      exp_cnt = exp_cnt + 8'd1;
      wait_until_edge(n + 8);
      if (i >= 255) check("wrap_press_cnt", {24'd0, press_cnt}, {24'd0, exp_cnt});
      key_n = 1'b1;
      m = edge_cnt + 1;
      push(K_RELEASE, m + 6);
      wait_until_edge(m + 8);
    end
    check("wrap_final_cnt", {24'd0, press_cnt}, 32'd0);
    check("wrap_press_seen", press_seen - p0, 256);
    check("wrap_release_seen", release_seen - r0, 256);
    check("wrap_long_seen", long_seen, 1);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
